branch_resolve_ctrl: RTL and testbench

ID-stage branch resolution controller for the 5-stage MIPS pipeline. It sequences the single equality comparator used for BEQ/BNE: it detects operand hazards against EX and MEM, stalls IF/ID until operands are valid, and selects forwarded or register-file operands. It then latches the compare result and issues a one-cycle resolution pulse with the taken decision. A stall watchdog flags protocol violations.

---
 rtl/branch_resolve_ctrl.sv | 128 ++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// ID-stage BEQ/BNE resolution: hazard detection against EX/MEM, operand forwarding,
// single-comparator resolve with a one-cycle result pulse and a sticky stall watchdog.
module branch_resolve_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MAX_STALL  = 2
) (
    input  logic                  clk__i,
    input  logic                  rst_n__i,
    input  logic                  branch_valid__i,
    input  logic                  branch_ne__i,
    input  logic [REG_ADDR_W-1:0] rs_addr__i,
    input  logic [REG_ADDR_W-1:0] rt_addr__i,
    input  logic [WIDTH-1:0]      rs_data__i,
    input  logic [WIDTH-1:0]      rt_data__i,
    input  logic                  ex_wr_en__i,
    input  logic                  ex_is_load__i,
    input  logic [REG_ADDR_W-1:0] ex_wr_addr__i,
    input  logic                  mem_wr_en__i,
    input  logic                  mem_is_load__i,
    input  logic [REG_ADDR_W-1:0] mem_wr_addr__i,
    input  logic [WIDTH-1:0]      mem_fwd_data__i,
    input  logic                  flush__i,
    output logic                  stall__o,
    output logic                  resolved__o,
    output logic                  taken__o,
    output logic                  stall_err__o
);

    localparam int unsigned       CNT_W   = $clog2(MAX_STALL + 2);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_STALL + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             resolved_q, resolved_d;
    logic             taken_q, taken_d;
    logic             stall_err_q, stall_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             ex_hz_rs, ex_hz_rt, mem_ld_hz_rs, mem_ld_hz_rt;
    logic             mem_fwd_rs, mem_fwd_rt, hazard, stall_c, taken_c;
    logic [WIDTH-1:0] op_a, op_b;

    // Any EX writer stalls one cycle whether ALU or load; load-ness only matters in MEM.
    logic unused_ex_is_load;
    assign unused_ex_is_load = ex_is_load__i;

    // Hazard detection and operand select; r0 never hazards, EX shadows MEM.
    always_comb begin
        ex_hz_rs     = (|rs_addr__i) & ex_wr_en__i & (ex_wr_addr__i == rs_addr__i);
        ex_hz_rt     = (|rt_addr__i) & ex_wr_en__i & (ex_wr_addr__i == rt_addr__i);
        mem_ld_hz_rs = (|rs_addr__i) & mem_wr_en__i & mem_is_load__i & (mem_wr_addr__i == rs_addr__i);
        mem_ld_hz_rt = (|rt_addr__i) & mem_wr_en__i & mem_is_load__i & (mem_wr_addr__i == rt_addr__i);
        mem_fwd_rs   = (|rs_addr__i) & mem_wr_en__i & ~mem_is_load__i
                       & (mem_wr_addr__i == rs_addr__i) & ~ex_hz_rs;
        mem_fwd_rt   = (|rt_addr__i) & mem_wr_en__i & ~mem_is_load__i
                       & (mem_wr_addr__i == rt_addr__i) & ~ex_hz_rt;
        hazard       = ex_hz_rs | ex_hz_rt | mem_ld_hz_rs | mem_ld_hz_rt;
        op_a         = mem_fwd_rs ? mem_fwd_data__i : rs_data__i;
        op_b         = mem_fwd_rt ? mem_fwd_data__i : rt_data__i;
        taken_c      = (op_a == op_b) ^ branch_ne__i;
        stall_c      = branch_valid__i & hazard & ~flush__i;
    end

    assign stall__o = stall_c & rst_n__i;

    // Next state, result latch and watchdog.
    always_comb begin
        state_d     = state_q;
        resolved_d  = 1'b0;
        taken_d     = taken_q;
        stall_cnt_d = '0;
        stall_err_d = stall_err_q;

        if (flush__i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                // A new branch is evaluated identically in every state, giving back-to-back resolves.
                IDLE, STALL, DONE: begin
                    if (!branch_valid__i) begin
                        state_d = IDLE;
                    end else if (hazard) begin
                        state_d = STALL;
                    end else begin
                        state_d    = DONE;
                        resolved_d = 1'b1;
                        taken_d    = taken_c;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (stall_c) begin
            stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
        end
        if (stall_cnt_d == CNT_MAX) begin
            stall_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk__i or negedge rst_n__i) begin
        if (!rst_n__i) begin
            state_q     <= IDLE;
            resolved_q  <= 1'b0;
            taken_q     <= 1'b0;
            stall_err_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            resolved_q  <= resolved_d;
            taken_q     <= taken_d;
            stall_err_q <= stall_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign resolved__o  = resolved_q;
    assign taken__o     = taken_q;
    assign stall_err__o = stall_err_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed cycle table, reset/flush sequences and
// randomized traffic checked against a rule-level reference model.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bv, bne, ex_we, ex_ld, mem_we, mem_ld, fl;
    logic [4:0]  rs_a, rt_a, ex_wa, mem_wa;
    logic [31:0] rs_d, rt_d, mem_fd;
    logic        stall, resolved, taken, serr;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        bv, bne;
        logic [4:0]  rs, rt;
        logic [31:0] rsd, rtd;
        logic        exwe, exld;
        logic [4:0]  exwa;
        logic        memwe, memld;
        logic [4:0]  memwa;
        logic [31:0] memfd;
        logic        fl;
        logic        e_stall, e_res, e_tkn, e_err;
    } vec_t;

    vec_t vecs[$];

    branch_resolve_ctrl dut (
        .clk__i          (clk),
        .rst_n__i        (rst_n),
        .branch_valid__i (bv),
        .branch_ne__i    (bne),
        .rs_addr__i      (rs_a),
        .rt_addr__i      (rt_a),
        .rs_data__i      (rs_d),
        .rt_data__i      (rt_d),
        .ex_wr_en__i     (ex_we),
        .ex_is_load__i   (ex_ld),
        .ex_wr_addr__i   (ex_wa),
        .mem_wr_en__i    (mem_we),
        .mem_is_load__i  (mem_ld),
        .mem_wr_addr__i  (mem_wa),
        .mem_fwd_data__i (mem_fd),
        .flush__i        (fl),
        .stall__o        (stall),
        .resolved__o     (resolved),
        .taken__o        (taken),
        .stall_err__o    (serr)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic bv_i, input logic bne_i, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [31:0] rsd, input logic [31:0] rtd,
                                input logic exwe, input logic exld, input logic [4:0] exwa,
                                input logic memwe, input logic memld, input logic [4:0] memwa, input logic [31:0] memfd,
                                input logic fl_i, input logic es, input logic er, input logic et, input logic ee);
        vec_t v;
        v.bv = bv_i; v.bne = bne_i; v.rs = rs; v.rt = rt; v.rsd = rsd; v.rtd = rtd;
        v.exwe = exwe; v.exld = exld; v.exwa = exwa;
        v.memwe = memwe; v.memld = memld; v.memwa = memwa; v.memfd = memfd;
        v.fl = fl_i; v.e_stall = es; v.e_res = er; v.e_tkn = et; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bv = v.bv; bne = v.bne; rs_a = v.rs; rt_a = v.rt; rs_d = v.rsd; rt_d = v.rtd;
        ex_we = v.exwe; ex_ld = v.exld; ex_wa = v.exwa;
        mem_we = v.memwe; mem_ld = v.memld; mem_wa = v.memwa; mem_fd = v.memfd;
        fl = v.fl;
    endtask

    // Drive on the falling edge, sample 1 time unit later, well before the next rising edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        chk({tag, " stall"}, 32'(stall), 32'(v.e_stall));
        chk({tag, " resolved"}, 32'(resolved), 32'(v.e_res));
        chk({tag, " stall_err"}, 32'(serr), 32'(v.e_err));
        if (v.e_res) chk({tag, " taken"}, 32'(taken), 32'(v.e_tkn));
    endtask

    // Reference model state: what the registered outputs should show next cycle.
    logic m_res, m_tkn, m_err;
    int   m_cnt;

    function automatic logic src_hazard(input vec_t v, input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        return (v.exwe && v.exwa == a) || (v.memwe && v.memld && v.memwa == a);
    endfunction

    function automatic logic [31:0] operand(input vec_t v, input logic [4:0] a, input logic [31:0] rf);
        if (a != 5'd0 && v.memwe && !v.memld && v.memwa == a && !(v.exwe && v.exwa == a)) return v.memfd;
        return rf;
    endfunction

    initial begin
        vec_t v;
        // bv bne rs rt rsd rtd | exwe exld exwa | memwe memld memwa memfd | fl | stall res tkn err
        vecs.push_back(mk(0,0, 0,0, 0,0,             0,0,0, 0,0,0,0,          0, 0,0,0,0));
        vecs.push_back(mk(1,0, 3,4, 5,5,             0,0,0, 0,0,0,0,          0, 0,0,0,0));
        vecs.push_back(mk(1,1, 3,4, 5,5,             0,0,0, 0,0,0,0,          0, 0,1,1,0));
        vecs.push_back(mk(0,0, 0,0, 0,0,             0,0,0, 0,0,0,0,          0, 0,1,0,0));
        vecs.push_back(mk(1,0, 8,2, 32'hdead,32'h1234, 1,0,8, 0,0,0,0,        0, 1,0,0,0));
        vecs.push_back(mk(1,0, 8,2, 32'hdead,32'h1234, 0,0,0, 1,0,8,32'h1234, 0, 0,0,0,0));
        vecs.push_back(mk(0,0, 0,0, 0,0,             0,0,0, 0,0,0,0,          0, 0,1,1,0));
        vecs.push_back(mk(1,1, 1,9, 1,32'h55,        1,1,9, 0,0,0,0,          0, 1,0,0,0));
        vecs.push_back(mk(1,1, 1,9, 1,32'h55,        0,0,0, 1,1,9,0,          0, 1,0,0,0));
        vecs.push_back(mk(1,1, 1,9, 1,0,             0,0,0, 0,0,0,0,          0, 0,0,0,0));
        vecs.push_back(mk(0,0, 0,0, 0,0,             0,0,0, 0,0,0,0,          0, 0,1,1,0));
        vecs.push_back(mk(1,0, 0,0, 0,0,             1,0,0, 1,0,0,32'h77,     0, 0,0,0,0));
        vecs.push_back(mk(0,0, 0,0, 0,0,             0,0,0, 0,0,0,0,          0, 0,1,1,0));
        vecs.push_back(mk(1,0, 3,4, 1,2,             0,0,0, 0,0,0,0,          0, 0,0,0,0));
        vecs.push_back(mk(1,1, 3,4, 1,2,             0,0,0, 0,0,0,0,          0, 0,1,0,0));
        vecs.push_back(mk(0,0, 0,0, 0,0,             0,0,0, 0,0,0,0,          0, 0,1,1,0));
        vecs.push_back(mk(1,0, 7,7, 9,9,             1,0,7, 0,0,0,0,          0, 1,0,0,0));
        vecs.push_back(mk(1,0, 7,7, 9,9,             1,0,7, 0,0,0,0,          0, 1,0,0,0));
        vecs.push_back(mk(1,0, 7,7, 9,9,             1,0,7, 0,0,0,0,          0, 1,0,0,0));
        vecs.push_back(mk(1,0, 7,7, 9,9,             0,0,0, 0,0,0,0,          0, 0,0,0,1));
        vecs.push_back(mk(0,0, 0,0, 0,0,             0,0,0, 0,0,0,0,          0, 0,1,1,1));
        vecs.push_back(mk(0,0, 0,0, 0,0,             0,0,0, 0,0,0,0,          0, 0,0,0,1));
        vecs.push_back(mk(1,0, 4,5, 1,1,             1,0,4, 0,0,0,0,          0, 1,0,0,1));
        vecs.push_back(mk(1,0, 4,5, 1,1,             1,0,4, 0,0,0,0,          1, 0,0,0,1));
        vecs.push_back(mk(0,0, 0,0, 0,0,             0,0,0, 0,0,0,0,          0, 0,0,0,1));
        vecs.push_back(mk(1,0, 3,4, 5,5,             0,0,0, 0,0,0,0,          1, 0,0,0,1));
        vecs.push_back(mk(0,0, 0,0, 0,0,             0,0,0, 0,0,0,0,          0, 0,0,0,1));
        vecs.push_back(mk(1,0, 6,2, 32'h10,32'h20,   1,0,6, 1,0,6,32'h20,     0, 1,0,0,1));
        vecs.push_back(mk(1,0, 6,2, 32'h10,32'h20,   0,0,0, 1,0,6,32'h20,     0, 0,0,0,1));
        vecs.push_back(mk(0,0, 0,0, 0,0,             0,0,0, 0,0,0,0,          0, 0,1,1,1));
        vecs.push_back(mk(1,0, 1,2, 3,4,             1,0,1, 1,1,2,0,          0, 1,0,0,1));
        vecs.push_back(mk(1,0, 1,2, 3,4,             0,0,0, 1,1,1,0,          0, 1,0,0,1));
        vecs.push_back(mk(1,0, 1,2, 3,4,             0,0,0, 0,0,0,0,          0, 0,0,0,1));
        vecs.push_back(mk(0,0, 0,0, 0,0,             0,0,0, 0,0,0,0,          0, 0,1,0,1));

        drive(vecs[0]);
        rst_n = 1'b0;
        #2;
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset resolved", 32'(resolved), 32'd0);
        chk("reset taken", 32'(taken), 32'd0);
        chk("reset stall_err", 32'(serr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Resolve a branch, then start a stalled one and pull reset mid-cycle.
        apply(mk(1,0, 3,4, 5,5, 0,0,0, 0,0,0,0, 0, 0,0,0,1), "pre_rst0");
        apply(mk(1,0, 3,4, 5,5, 1,0,3, 0,0,0,0, 0, 1,1,1,1), "pre_rst1");
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst stall", 32'(stall), 32'd0);
        chk("async_rst resolved", 32'(resolved), 32'd0);
        chk("async_rst taken", 32'(taken), 32'd0);
        chk("async_rst stall_err", 32'(serr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        m_res = 1'b0; m_tkn = 1'b0; m_err = 1'b0; m_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            logic hz;
            logic [31:0] a, b;
            v = mk($urandom_range(0,9) < 7, 1'($urandom_range(0,1)),
                   5'($urandom_range(0,3)), 5'($urandom_range(0,3)),
                   32'($urandom_range(0,2)), 32'($urandom_range(0,2)),
                   1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 5'($urandom_range(0,3)),
                   1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 5'($urandom_range(0,3)),
                   32'($urandom_range(0,2)), $urandom_range(0,15) == 0,
                   1'b0, 1'b0, 1'b0, 1'b0);
            hz = src_hazard(v, v.rs) || src_hazard(v, v.rt);
            v.e_stall = v.bv && hz && !v.fl;
            v.e_res = m_res; v.e_tkn = m_tkn; v.e_err = m_err;
            apply(v, $sformatf("rnd%0d", c));
            a = operand(v, v.rs, v.rsd);
            b = operand(v, v.rt, v.rtd);
            if (v.fl) m_res = 1'b0;
            else if (v.bv && !hz) begin
                m_res = 1'b1;
                m_tkn = (a == b) != v.bne;
            end else m_res = 1'b0;
            m_cnt = v.e_stall ? ((m_cnt < 3) ? m_cnt + 1 : 3) : 0;
            if (m_cnt >= 3) m_err = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
